operand_fetch: RTL and testbench

- Register-read stage between instruction decode and execute in the RV32 core.
- Drives the register bank read addresses, captures both operands into a one-entry ID/EX output register, and forwards the writeback result into the bank's write port.
- Keeps a per-register scoreboard of in-flight destinations and stalls decode on RAW/WAW hazards.
- Valid/ready handshake on both sides.

---
 rtl/operand_fetch.sv | 132 +++++++++++++
 tb/tb_operand_fetch.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Register-read stage: bank read, one-entry ID/EX register, scoreboard and wb forwarding.
// Same-cycle writeback bypass is enabled by defining OPFETCH_BYPASS_EN.
module operand_fetch #(
    parameter int BIT_WIDTH  = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [ADDR_WIDTH-1:0] inRs1,
    input  logic [ADDR_WIDTH-1:0] inRs2,
    input  logic [ADDR_WIDTH-1:0] inRd,
    input  logic                  inUsesRs1,
    input  logic                  inUsesRs2,
    input  logic                  inWritesRd,
    input  logic [CTRL_WIDTH-1:0] inCtrl,
    output logic [ADDR_WIDTH-1:0] readAddr1,
    output logic [ADDR_WIDTH-1:0] readAddr2,
    input  logic [BIT_WIDTH-1:0]  readData1,
    input  logic [BIT_WIDTH-1:0]  readData2,
    input  logic                  wbEn,
    input  logic [ADDR_WIDTH-1:0] wbAddr,
    input  logic [BIT_WIDTH-1:0]  wbData,
    output logic                  writeEn,
    output logic [ADDR_WIDTH-1:0] writeAddr,
    output logic [BIT_WIDTH-1:0]  writeData,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [BIT_WIDTH-1:0]  outOp1,
    output logic [BIT_WIDTH-1:0]  outOp2,
    output logic [ADDR_WIDTH-1:0] outRd,
    output logic                  outWritesRd,
    output logic [CTRL_WIDTH-1:0] outCtrl,
    input  logic                  flush
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [NREG-1:0]      pend;
    logic [NREG-1:0]      pendNext;
    logic                 byp1;
    logic                 byp2;
    logic                 raw1;
    logic                 raw2;
    logic                 waw;
    logic                 hazard;
    logic                 fire;
    logic                 wbLive;
    logic [BIT_WIDTH-1:0] op1;
    logic [BIT_WIDTH-1:0] op2;

    assign readAddr1 = inRs1;
    assign readAddr2 = inRs2;

    assign wbLive    = wbEn && (wbAddr != '0);
    assign writeEn   = wbLive;
    assign writeAddr = wbAddr;
    assign writeData = wbData;

`ifdef OPFETCH_BYPASS_EN
    assign byp1 = wbEn && (wbAddr == inRs1);
    assign byp2 = wbEn && (wbAddr == inRs2);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign raw1 = inUsesRs1 && (inRs1 != '0) && pend[inRs1] && !byp1;
    assign raw2 = inUsesRs2 && (inRs2 != '0) && pend[inRs2] && !byp2;
    // A writeback to the same rd this cycle retires the older writer, so no WAW.
    assign waw  = inWritesRd && (inRd != '0) && pend[inRd]
                  && !(wbEn && (wbAddr == inRd));

    assign hazard  = raw1 || raw2 || waw;
    assign inReady = (!outValid || outReady) && !hazard && !flush;
    assign fire    = inValid && inReady;

    always_comb begin
        op1 = readData1;
        if (inRs1 == '0) op1 = '0;
        else if (byp1)   op1 = wbData;
    end

    always_comb begin
        op2 = readData2;
        if (inRs2 == '0) op2 = '0;
        else if (byp2)   op2 = wbData;
    end

    // Clear first so a same-cycle set on the same index wins.
    always_comb begin
        pendNext = pend;
        if (wbLive) pendNext[wbAddr] = 1'b0;
        if (fire && inWritesRd && (inRd != '0)) pendNext[inRd] = 1'b1;
        pendNext[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pend <= '0;
        end else if (flush) begin
            pend <= '0;
        end else begin
            pend <= pendNext;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            outValid    <= 1'b0;
            outOp1      <= '0;
            outOp2      <= '0;
            outRd       <= '0;
            outWritesRd <= 1'b0;
            outCtrl     <= '0;
        end else if (flush) begin
            outValid <= 1'b0;
        end else if (fire) begin
            outValid    <= 1'b1;
            outOp1      <= op1;
            outOp2      <= op2;
            outRd       <= inRd;
            outWritesRd <= inWritesRd;
            outCtrl     <= inCtrl;
        end else if (outReady) begin
            outValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a small register-bank model.
// Bypass-dependent expectations follow OPFETCH_BYPASS_EN.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rstN;
    logic        inValid;
    logic        inReady;
    logic [4:0]  inRs1, inRs2, inRd;
    logic        inUsesRs1, inUsesRs2, inWritesRd;
    logic [15:0] inCtrl;
    logic [4:0]  readAddr1, readAddr2;
    logic [31:0] readData1, readData2;
    logic        wbEn;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
    logic        writeEn;
    logic [4:0]  writeAddr;
    logic [31:0] writeData;
    logic        outValid;
    logic        outReady;
    logic [31:0] outOp1, outOp2;
    logic [4:0]  outRd;
    logic        outWritesRd;
    logic [15:0] outCtrl;
    logic        flush;

    logic [31:0] bank [32];
    int nChecks = 0;
    int nPass   = 0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .rstN(rstN),
        .inValid(inValid), .inReady(inReady),
        .inRs1(inRs1), .inRs2(inRs2), .inRd(inRd),
        .inUsesRs1(inUsesRs1), .inUsesRs2(inUsesRs2),
        .inWritesRd(inWritesRd), .inCtrl(inCtrl),
        .readAddr1(readAddr1), .readAddr2(readAddr2),
        .readData1(readData1), .readData2(readData2),
        .wbEn(wbEn), .wbAddr(wbAddr), .wbData(wbData),
        .writeEn(writeEn), .writeAddr(writeAddr),
        .writeData(writeData),
        .outValid(outValid), .outReady(outReady),
        .outOp1(outOp1), .outOp2(outOp2), .outRd(outRd),
        .outWritesRd(outWritesRd), .outCtrl(outCtrl),
        .flush(flush)
    );

    assign readData1 = bank[readAddr1];
    assign readData2 = bank[readAddr2];

    always @(posedge clk) begin
        if (!rstN) begin
            for (int i = 0; i < 32; i++) bank[i] <= '0;
            bank[3] <= 32'h11;
            bank[4] <= 32'h22;
        end else if (writeEn) begin
            bank[writeAddr] <= writeData;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2,
                         input logic [4:0] rd, input logic wr,
                         input logic [15:0] ctrl);
        inValid = 1'b1;
        inRs1 = rs1; inRs2 = rs2;
        inUsesRs1 = u1; inUsesRs2 = u2;
        inRd = rd; inWritesRd = wr;
        inCtrl = ctrl;
        #1;
    endtask

    task automatic idle();
        inValid = 1'b0;
        inUsesRs1 = 1'b0; inUsesRs2 = 1'b0; inWritesRd = 1'b0;
        inRs1 = '0; inRs2 = '0; inRd = '0;
        #1;
    endtask

    initial begin
        rstN = 1'b0; flush = 1'b0; outReady = 1'b1;
        wbEn = 1'b0; wbAddr = '0; wbData = '0; inCtrl = '0;
        idle();
        tick(); tick();
        check("rst_outValid", {31'b0, outValid}, 32'h0);
        check("rst_outOp1", outOp1, 32'h0);
        check("rst_outCtrl", {16'h0, outCtrl}, 32'h0);
        rstN = 1'b1;
        tick();
        check("rst_inReady", {31'b0, inReady}, 32'h1);

        // basic read of x3/x4
        issue(5'd3, 5'd4, 1, 1, 5'd0, 0, 16'h1234);
        check("basic_inReady", {31'b0, inReady}, 32'h1);
        tick();
        check("basic_outValid", {31'b0, outValid}, 32'h1);
        check("basic_op1", outOp1, 32'h11);
        check("basic_op2", outOp2, 32'h22);
        check("basic_ctrl", {16'h0, outCtrl}, 32'h1234);
        idle();
        tick();
        check("basic_drain", {31'b0, outValid}, 32'h0);

        // writer of x5, then dependent reader stalls
        issue(5'd0, 5'd0, 0, 0, 5'd5, 1, 16'h0005);
        tick();
        check("wr5_outRd", {27'b0, outRd}, 32'd5);
        issue(5'd5, 5'd0, 1, 0, 5'd0, 0, 16'h0006);
        check("raw_stall0", {31'b0, inReady}, 32'h0);
        tick(); tick(); tick();
        check("raw_stall3", {31'b0, inReady}, 32'h0);
        check("raw_noValid", {31'b0, outValid}, 32'h0);
        issue(5'd0, 5'd0, 0, 0, 5'd5, 1, 16'h0007);
        check("waw_stall", {31'b0, inReady}, 32'h0);
        issue(5'd5, 5'd0, 1, 0, 5'd0, 0, 16'h0006);

        // writeback of x5 in the stall cycle
        wbEn = 1'b1; wbAddr = 5'd5; wbData = 32'hABCD;
        #1;
        check("wb5_writeEn", {31'b0, writeEn}, 32'h1);
`ifdef OPFETCH_BYPASS_EN
        check("byp_inReady", {31'b0, inReady}, 32'h1);
        tick();
        wbEn = 1'b0;
`else
        check("nobyp_inReady", {31'b0, inReady}, 32'h0);
        tick();
        wbEn = 1'b0;
        #1;
        check("nobyp_release", {31'b0, inReady}, 32'h1);
        tick();
`endif
        check("wb5_outValid", {31'b0, outValid}, 32'h1);
        check("wb5_op1", outOp1, 32'hABCD);
        idle();
        tick();

        // x0 source/destination with a wb to x0
        wbEn = 1'b1; wbAddr = 5'd0; wbData = 32'h55;
        issue(5'd0, 5'd0, 1, 1, 5'd0, 1, 16'h00F0);
        check("x0_writeEn", {31'b0, writeEn}, 32'h0);
        check("x0_inReady", {31'b0, inReady}, 32'h1);
        tick();
        wbEn = 1'b0;
        check("x0_op1", outOp1, 32'h0);
        check("x0_op2", outOp2, 32'h0);
        check("x0_wr", {31'b0, outWritesRd}, 32'h1);
        issue(5'd0, 5'd0, 1, 0, 5'd0, 1, 16'h00F1);
        check("x0_noWaw", {31'b0, inReady}, 32'h1);
        idle();
        tick();

        // backpressure holds the entry stable
        outReady = 1'b0;
        issue(5'd3, 5'd4, 1, 1, 5'd0, 0, 16'h00A1);
        tick();
        issue(5'd4, 5'd3, 1, 1, 5'd0, 0, 16'h00B2);
        check("bp_inReady", {31'b0, inReady}, 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("bp_hold_op1", outOp1, 32'h11);
            check("bp_hold_op2", outOp2, 32'h22);
            check("bp_hold_ctrl", {16'h0, outCtrl}, 32'h00A1);
        end
        outReady = 1'b1;
        #1;
        check("bp_release", {31'b0, inReady}, 32'h1);
        tick();
        check("bp_next_valid", {31'b0, outValid}, 32'h1);
        check("bp_next_op1", outOp1, 32'h22);
        check("bp_next_ctrl", {16'h0, outCtrl}, 32'h00B2);
        idle();
        tick();

        // flush clears outValid and the scoreboard
        issue(5'd0, 5'd0, 0, 0, 5'd7, 1, 16'h0700);
        tick();
        idle();
        flush = 1'b1;
        issue(5'd7, 5'd0, 1, 0, 5'd0, 0, 16'h0701);
        check("flush_inReady", {31'b0, inReady}, 32'h0);
        tick();
        flush = 1'b0;
        #1;
        check("flush_outValid", {31'b0, outValid}, 32'h0);
        check("flush_noStall", {31'b0, inReady}, 32'h1);

        // set and clear of x7 in one cycle: set wins
        wbEn = 1'b1; wbAddr = 5'd7; wbData = 32'h77;
        issue(5'd0, 5'd0, 0, 0, 5'd7, 1, 16'h0702);
        check("setwin_fire", {31'b0, inReady}, 32'h1);
        tick();
        wbEn = 1'b0;
        issue(5'd7, 5'd0, 1, 0, 5'd0, 0, 16'h0703);
        check("setwin_stall", {31'b0, inReady}, 32'h0);
        idle();
        wbEn = 1'b1; wbAddr = 5'd7; wbData = 32'h78;
        tick();
        wbEn = 1'b0;
        issue(5'd7, 5'd0, 1, 0, 5'd0, 0, 16'h0704);
        check("x7_cleared", {31'b0, inReady}, 32'h1);
        tick();
        check("x7_op1", outOp1, 32'h78);

        // asynchronous reset drops a held entry
        outReady = 1'b0;
        idle();
        check("rstmid_pre", {31'b0, outValid}, 32'h1);
        rstN = 1'b0;
        #1;
        check("rstmid_outValid", {31'b0, outValid}, 32'h0);
        check("rstmid_op1", outOp1, 32'h0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
